ff_response_checker: RTL and testbench

//  Receiving end of the flip-flop stimulus benches: watches the same D/K stimulus

---
 rtl/ff_response_checker.sv | 117 +++++++++++
 tb/tb_ff_response_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ff_response_checker.sv
// Reference-model checker for a D, T or JK flop under test: mirrors the flop from its
// stimulus, compares the observed Q every enabled edge and keeps saturating tallies.
module ff_response_checker #(
  parameter int MODE     = 0,
  parameter int CNT_W    = 8,
  parameter int SETTLE   = 2,
  parameter int STOP_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_in,
  input  logic             k_in,
  input  logic             q_obs,
  output logic             q_exp,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic [1:0]       state,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  localparam int             SW          = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]  SETTLE_INIT = SW'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  function automatic logic model_next(input logic q, input logic d, input logic k);
    case (MODE)
      1: return q ^ d;
      2: begin
        case ({d, k})
          2'b00:   return q;
          2'b01:   return 1'b0;
          2'b10:   return 1'b1;
          default: return ~q;
        endcase
      end
      default: return d;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic             r_q_exp;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_first_err;
  logic [SW-1:0]    r_settle;

  logic             w_q_next;
  logic             w_diff;
  logic [CNT_W-1:0] w_chk_inc;

  assign w_q_next  = model_next(r_q_exp, d_in, k_in);
  assign w_diff    = q_obs ^ r_q_exp;
  assign w_chk_inc = sat_inc(r_chk_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q_exp     <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_first_err <= '0;
      r_settle    <= SETTLE_INIT;
    end else if (!en) begin
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_SYNC;
        // Seed from the observed Q so the model starts aligned with whatever the flop holds.
        S_SYNC: begin
          r_q_exp <= model_next(q_obs, d_in, k_in);
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_q_exp <= w_q_next;
          if (r_settle != '0) begin
            r_settle <= r_settle - SW'(1);
          end else begin
            r_chk_cnt <= w_chk_inc;
            if (w_diff) begin
              r_mismatch <= 1'b1;
              r_err_cnt  <= sat_inc(r_err_cnt);
              if (r_err_cnt == '0) r_first_err <= w_chk_inc;
              if (STOP_ERR != 0) r_state <= S_FAIL;
            end
          end
        end
        default: r_state <= S_FAIL;
      endcase
    end
  end

  assign q_exp     = r_q_exp;
  assign mismatch  = r_mismatch;
  assign err_cnt   = r_err_cnt;
  assign chk_cnt   = r_chk_cnt;
  assign first_err = r_first_err;
  assign state     = r_state;
  assign pass      = (r_state == S_CHECK) && (r_chk_cnt != '0) && (r_err_cnt == '0);

endmodule

// File: tb/tb_ff_response_checker.sv
// Bench for ff_response_checker: five checker configurations watch bench-modelled flops
// driven by one shared stimulus stream, with Q corruption injected per instance.
module tb_ff_response_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       d_in = 1'b0;
  logic       k_in = 1'b0;
  logic [4:0] qt = '0;
  logic [4:0] cor_eff = '0;
  logic [4:0] q_obs;
  logic [4:0] qe, mm, ps;
  logic [1:0] st [5];
  logic [7:0] ec [4];
  logic [7:0] cc [4];
  logic [7:0] fe [4];
  logic [2:0] ec4, cc4, fe4;

  localparam int MODE_V   [5] = '{0, 1, 2, 0, 0};
  localparam int SETTLE_V [5] = '{0, 2, 0, 0, 0};
  localparam int STOP_V   [5] = '{0, 0, 0, 1, 0};
  localparam int CMAX_V   [5] = '{255, 255, 255, 255, 7};

  int n_chk = 0;
  int n_pass = 0;
  int edges [5];
  int mchk [5];
  int merr [5];
  int mfe [5];
  bit stopped [5];
  logic [4:0] sb_q [$];

  always #5 clk = ~clk;

  assign q_obs = qt ^ cor_eff;

  ff_response_checker #(.MODE(0), .CNT_W(8), .SETTLE(0), .STOP_ERR(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .k_in(k_in), .q_obs(q_obs[0]),
    .q_exp(qe[0]), .mismatch(mm[0]), .err_cnt(ec[0]), .chk_cnt(cc[0]),
    .first_err(fe[0]), .state(st[0]), .pass(ps[0]));
  ff_response_checker #(.MODE(1), .CNT_W(8), .SETTLE(2), .STOP_ERR(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .k_in(k_in), .q_obs(q_obs[1]),
    .q_exp(qe[1]), .mismatch(mm[1]), .err_cnt(ec[1]), .chk_cnt(cc[1]),
    .first_err(fe[1]), .state(st[1]), .pass(ps[1]));
  ff_response_checker #(.MODE(2), .CNT_W(8), .SETTLE(0), .STOP_ERR(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .k_in(k_in), .q_obs(q_obs[2]),
    .q_exp(qe[2]), .mismatch(mm[2]), .err_cnt(ec[2]), .chk_cnt(cc[2]),
    .first_err(fe[2]), .state(st[2]), .pass(ps[2]));
  ff_response_checker #(.MODE(0), .CNT_W(8), .SETTLE(0), .STOP_ERR(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .k_in(k_in), .q_obs(q_obs[3]),
    .q_exp(qe[3]), .mismatch(mm[3]), .err_cnt(ec[3]), .chk_cnt(cc[3]),
    .first_err(fe[3]), .state(st[3]), .pass(ps[3]));
  ff_response_checker #(.MODE(0), .CNT_W(3), .SETTLE(0), .STOP_ERR(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .d_in(d_in), .k_in(k_in), .q_obs(q_obs[4]),
    .q_exp(qe[4]), .mismatch(mm[4]), .err_cnt(ec4), .chk_cnt(cc4),
    .first_err(fe4), .state(st[4]), .pass(ps[4]));

  function automatic logic ref_next(input int mode, input logic q, input logic d, input logic k);
    if (mode == 1) return q ^ d;
    if (mode == 2) begin
      if (!d && !k) return q;
      if (!d && k)  return 1'b0;
      if (d && !k)  return 1'b1;
      return ~q;
    end
    return d;
  endfunction

  // Flops under test: clock gated by en, no reset of their own.
  always @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 5; i++) qt[i] <= ref_next(MODE_V[i], qt[i], d_in, k_in);
    end
  end

  function automatic logic [31:0] g_err(input int i);
    if (i == 4) return {29'b0, ec4};
    return {24'b0, ec[i]};
  endfunction
  function automatic logic [31:0] g_chk(input int i);
    if (i == 4) return {29'b0, cc4};
    return {24'b0, cc[i]};
  endfunction
  function automatic logic [31:0] g_fe(input int i);
    if (i == 4) return {29'b0, fe4};
    return {24'b0, fe[i]};
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      edges[i] = 0; mchk[i] = 0; merr[i] = 0; mfe[i] = 0; stopped[i] = 0;
    end
  endtask

  task automatic check_counts();
    int exp_st;
    for (int i = 0; i < 5; i++) begin
      exp_st = stopped[i] ? 3 : (edges[i] == 0) ? 0 : (edges[i] == 1) ? 1 : 2;
      check("err_cnt", i, g_err(i), mchk[i] >= 0 ? merr[i] : 0);
      check("chk_cnt", i, g_chk(i), mchk[i]);
      check("first_err", i, g_fe(i), mfe[i]);
      check("state", i, 32'(st[i]), exp_st);
      check("pass", i, 32'(ps[i]), (exp_st == 2 && mchk[i] != 0 && merr[i] == 0) ? 1 : 0);
    end
  endtask

  task automatic do_reset(input bit e);
    @(negedge clk);
    rst = 1'b1; en = e; d_in = 1'b0; k_in = 1'b0; cor_eff = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      check("rst_state", i, 32'(st[i]), 0);
      check("rst_err", i, g_err(i), 0);
      check("rst_chk", i, g_chk(i), 0);
      check("rst_first", i, g_fe(i), 0);
      check("rst_mismatch", i, 32'(mm[i]), 0);
      check("rst_qexp", i, 32'(qe[i]), 0);
      check("rst_pass", i, 32'(ps[i]), 0);
    end
  endtask

  // cor: per-instance request to invert q_obs; honoured on compare edges and in FAIL.
  task automatic step(input bit e, input bit d, input bit k, input logic [4:0] cor);
    logic [4:0] exp_mm;
    logic [4:0] ce;
    @(negedge clk);
    en = e; d_in = d; k_in = k;
    exp_mm = '0; ce = '0;
    for (int i = 0; i < 5; i++) begin
      if (e) begin
        edges[i]++;
        if (stopped[i]) begin
          ce[i] = cor[i];
        end else if (edges[i] > 2 + SETTLE_V[i]) begin
          ce[i] = cor[i];
          if (mchk[i] < CMAX_V[i]) mchk[i]++;
          if (cor[i]) begin
            exp_mm[i] = 1'b1;
            if (merr[i] == 0) mfe[i] = mchk[i];
            if (merr[i] < CMAX_V[i]) merr[i]++;
            if (STOP_V[i] != 0) stopped[i] = 1;
          end
        end
      end
    end
    cor_eff = ce;
    sb_q.push_back(exp_mm);
    @(posedge clk);
    #1;
    exp_mm = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("mismatch", i, 32'(mm[i]), 32'(exp_mm[i]));
      if (edges[i] < 2) check("qexp_idle", i, 32'(qe[i]), 0);
      else if (!stopped[i]) check("qexp_track", i, 32'(qe[i]), 32'(qt[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cor;
    model_clear();
    repeat (2) @(posedge clk);

    // Phase A: D toggling; inject errors into T, STOP_ERR and CNT_W=3 checkers.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      cor = '0;
      if (i == 9) cor[1] = 1'b1;
      if (i == 4 || i >= 10) cor[3] = 1'b1;
      if (i >= 2 && i <= 13) cor[4] = 1'b1;
      step(1'b1, (i % 2) == 1, 1'b0, cor);
    end
    check_counts();
    check("A_d_chk", 0, g_chk(0), 18);
    check("A_d_err", 0, g_err(0), 0);
    check("A_d_pass", 0, 32'(ps[0]), 1);
    check("A_t_err", 1, g_err(1), 1);
    check("A_t_first", 1, g_fe(1), 6);
    check("A_stop_state", 3, 32'(st[3]), 3);
    check("A_stop_chk", 3, g_chk(3), 3);
    check("A_stop_err", 3, g_err(3), 1);
    check("A_sat_err", 4, g_err(4), 7);
    check("A_sat_chk", 4, g_chk(4), 7);

    // Phase B: JK cycled 00,01,10,11 into a correct JK flop.
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, (i % 4) >= 2, (i % 2) == 1, 5'b0);
    check_counts();
    check("B_jk_err", 2, g_err(2), 0);
    check("B_jk_chk", 2, g_chk(2), 14);

    // Phase C: same JK pattern with the observed Q stuck at 0.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      cor = '0;
      cor[2] = qt[2];
      step(1'b1, (i % 4) >= 2, (i % 2) == 1, cor);
    end
    check_counts();
    check("C_stuck_err", 2, g_err(2), 4);
    check("C_stuck_chk", 2, g_chk(2), 14);
    check("C_stuck_first", 2, g_fe(2), 2);

    // Phase D: enable dropped mid-check with the flop clock gated alongside.
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom), 1'($urandom), 5'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'($urandom), 5'b0);
    check_counts();
    check("D_hold_chk", 0, g_chk(0), 6);
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'($urandom), 5'b0);
    check_counts();
    check("D_resume_chk", 1, g_chk(1), 10);
    check("D_resume_err", 0, g_err(0), 0);
    do_reset(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
